// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: periodically sends read-keys (0x42), shifts in 4 scan bytes, publishes 8 keys.
// Optional KEY_DEBOUNCE_EN: keys only update after two identical consecutive scans.
module tm1638_key_reader #(
   parameter int CLK_DIV     = 50,
   parameter int WAIT_CYC    = 100,
   parameter int SCAN_PERIOD = 500000
) (
   input  logic       clk_50M,
   input  logic       rst,
   input  logic       bus_gnt,
   input  logic       dio_in,
   output logic       bus_req,
   output logic       busy,
   output logic       tm_clk,
   output logic       stb,
   output logic       dio_out,
   output logic       dio_oe,
   output logic [7:0] keys,
   output logic       keys_valid
);

   // state      | meaning
   // S_IDLE     | scan timer running, bus released
   // S_REQ      | requesting bus, waiting for grant
   // S_STB_LOW  | stb low, tm_clk high setup phase
   // S_CMD      | shifting out 0x42, LSB first
   // S_WAIT     | DIO released, gap before read
   // S_READ     | shifting in 32 scan bits
   // S_STB_HIGH | final tm_clk high phase before stb rises
   // S_DONE     | stb high, keys published
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_STB_LOW, S_CMD, S_WAIT, S_READ, S_STB_HIGH, S_DONE
   } state_t;

   localparam int PH_MAX = (CLK_DIV > WAIT_CYC) ? CLK_DIV : WAIT_CYC;
   localparam int CNT_W  = $clog2(PH_MAX + 1);
   localparam int SCAN_W = $clog2(SCAN_PERIOD + 1);
   localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYC - 1);
   localparam logic [SCAN_W-1:0] SCAN_TC   = SCAN_W'(SCAN_PERIOD - 1);
   localparam logic [7:0]        CMD_BYTE  = 8'h42;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [SCAN_W-1:0]   scan_cnt;
   logic [4:0]          bit_cnt;
   logic                ph;
   logic [1:0]          dio_sync;
   logic [7:0]          raw_keys;
   logic                cnt_tc;
   logic                phase_end;
`ifdef KEY_DEBOUNCE_EN
   logic [7:0]          prev_raw;
`endif

   assign cnt_tc    = (cnt == '0);
   assign phase_end = cnt_tc && ph;

   always_comb begin
      state_nxt = state;
      bus_req   = 1'b0;
      busy      = 1'b0;
      stb       = 1'b1;
      tm_clk    = 1'b1;
      dio_out   = 1'b1;
      dio_oe    = 1'b0;
      case (state)
         S_IDLE: begin
            if (scan_cnt == SCAN_TC) state_nxt = S_REQ;
         end
         S_REQ: begin
            bus_req = 1'b1;
            busy    = 1'b1;
            if (bus_gnt) state_nxt = S_STB_LOW;
         end
         S_STB_LOW: begin
            bus_req = 1'b1;
            busy    = 1'b1;
            stb     = 1'b0;
            if (cnt_tc) state_nxt = S_CMD;
         end
         S_CMD: begin
            bus_req = 1'b1;
            busy    = 1'b1;
            stb     = 1'b0;
            tm_clk  = ph;
            dio_oe  = 1'b1;
            dio_out = CMD_BYTE[bit_cnt[2:0]];
            if (phase_end && bit_cnt == 5'd7) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            bus_req = 1'b1;
            busy    = 1'b1;
            stb     = 1'b0;
            if (cnt_tc) state_nxt = S_READ;
         end
         S_READ: begin
            bus_req = 1'b1;
            busy    = 1'b1;
            stb     = 1'b0;
            tm_clk  = ph;
            if (phase_end && bit_cnt == 5'd31) state_nxt = S_STB_HIGH;
         end
         S_STB_HIGH: begin
            bus_req = 1'b1;
            busy    = 1'b1;
            stb     = 1'b0;
            if (cnt_tc) state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         scan_cnt   <= '0;
         bit_cnt    <= '0;
         ph         <= 1'b0;
         dio_sync   <= 2'b11;
         raw_keys   <= '0;
         keys       <= '0;
         keys_valid <= 1'b0;
`ifdef KEY_DEBOUNCE_EN
         prev_raw   <= '0;
`endif
      end else begin
         state      <= state_nxt;
         dio_sync   <= {dio_sync[0], dio_in};
         keys_valid <= 1'b0;
         case (state)
            S_IDLE: scan_cnt <= (state_nxt == S_REQ) ? '0 : scan_cnt + 1'b1;
            S_REQ:  cnt <= DIV_LOAD;
            S_STB_LOW, S_STB_HIGH, S_WAIT: begin
               if (!cnt_tc) cnt <= cnt - 1'b1;
               else begin
                  cnt     <= DIV_LOAD;
                  ph      <= 1'b0;
                  bit_cnt <= '0;
               end
            end
            S_CMD, S_READ: begin
               if (!cnt_tc) cnt <= cnt - 1'b1;
               else begin
                  // only bits 0 and 4 of each scan byte carry LED&KEY buttons
                  if (state == S_READ && ph && bit_cnt[1:0] == 2'b00)
                     raw_keys[{bit_cnt[2], bit_cnt[4:3]}] <= dio_sync[1];
                  cnt <= (state_nxt == S_WAIT) ? WAIT_LOAD : DIV_LOAD;
                  ph  <= ~ph;
                  if (ph) bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_DONE: begin
`ifdef KEY_DEBOUNCE_EN
               prev_raw <= raw_keys;
               if (raw_keys == prev_raw && raw_keys != keys) begin
                  keys       <= raw_keys;
                  keys_valid <= 1'b1;
               end
`else
               keys       <= raw_keys;
               keys_valid <= 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
